// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline controller.
// Holds the FSM state enumeration, the phase-counter type and the default values of the
// controller parameters (branch penalty, drain length, performance-counter width).
// Optional feature macro: PIPELINE_CTRL_STEP_EN adds the single-step state.
package pipeline_ctrl_pkg;

  localparam int unsigned BranchPenaltyDefault = 2;
  localparam int unsigned DrainCyclesDefault   = 4;
  localparam int unsigned CntWDefault          = 16;

  // Wide enough for the longest phase (DRAIN_CYCLES up to 15).
  localparam int unsigned PhaseCntW = 4;
  typedef logic [PhaseCntW-1:0] phase_cnt_t;

`ifdef PIPELINE_CTRL_STEP_EN
  typedef enum logic [2:0] {
    StRun,
    StFlush,
    StDrain,
    StHalted,
    StStep
  } state_e;
`else
  typedef enum logic [2:0] {
    StRun,
    StFlush,
    StDrain,
    StHalted
  } state_e;
`endif

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in EX is a load whose destination (Rt, non-zero) is read by the
// instruction currently in ID, either through Rs or, when the ID instruction uses it, Rt.
// Ports:
//   mem_read_i    - MemRead of the ID/EX instruction
//   ex_rt_i       - destination register of the ID/EX instruction
//   id_rs_i       - Rs of the ID instruction
//   id_rt_i       - Rt of the ID instruction
//   id_uses_rt_i  - ID instruction reads Rt
//   hazard_o      - load-use hazard present
module load_use_detect (
  input  logic       mem_read_i,
  input  logic [4:0] ex_rt_i,
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_uses_rt_i,
  output logic       hazard_o
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (ex_rt_i == id_rs_i);
    rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);
    // r0 is hard-wired to zero, so a load into it never creates a dependency.
    hazard_o = mem_read_i && (ex_rt_i != 5'd0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard / flush / halt controller.
// Decodes load-use stalls, taken-branch flushes and halt draining into the PC and pipeline
// latch controls, and keeps saturating counters of stall and flush cycles.
// Outputs are combinational from the current state and inputs; all are forced low while
// reset is asserted.
// Optional feature macro: PIPELINE_CTRL_STEP_EN enables single-stepping out of HALTED.
// Ports:
//   clk, reset (sync, active-low)
//   exMemRead, exRegRt          - ID/EX instruction load info
//   idRegRs, idRegRt, idUsesRt  - ID instruction source registers
//   exBranchTaken, idHalt, step - control events
//   pcEnable, ifIdEnable, idExEnable, ifIdFlush, idExFlush, halted - pipeline controls
//   stallCount, flushCount      - saturating performance counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned BRANCH_PENALTY = BranchPenaltyDefault,
  parameter int unsigned DRAIN_CYCLES   = DrainCyclesDefault,
  parameter int unsigned CNT_W          = CntWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             exMemRead,
  input  logic [4:0]       exRegRt,
  input  logic [4:0]       idRegRs,
  input  logic [4:0]       idRegRt,
  input  logic             idUsesRt,
  input  logic             exBranchTaken,
  input  logic             idHalt,
  input  logic             step,
  output logic             pcEnable,
  output logic             ifIdEnable,
  output logic             idExEnable,
  output logic             ifIdFlush,
  output logic             idExFlush,
  output logic             halted,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  state_e           state_q;
  phase_cnt_t       cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic hazard;
  logic branch_evt;
  logic stall_evt;
  logic halt_evt;
  logic flush_evt;

`ifndef PIPELINE_CTRL_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  load_use_detect u_load_use_detect (
    .mem_read_i   (exMemRead),
    .ex_rt_i      (exRegRt),
    .id_rs_i      (idRegRs),
    .id_rt_i      (idRegRt),
    .id_uses_rt_i (idUsesRt),
    .hazard_o     (hazard)
  );

  // Event priority in RUN: branch > load-use stall > halt.
  always_comb begin
    branch_evt = (state_q == StRun) && exBranchTaken;
    stall_evt  = (state_q == StRun) && !exBranchTaken && hazard;
    halt_evt   = (state_q == StRun) && !exBranchTaken && !hazard && idHalt;
    flush_evt  = branch_evt || (state_q == StFlush);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (branch_evt) begin
            if (BRANCH_PENALTY > 1) begin
              state_q <= StFlush;
              cnt_q   <= phase_cnt_t'(BRANCH_PENALTY - 1);
            end
          end else if (halt_evt) begin
            state_q <= StDrain;
            cnt_q   <= phase_cnt_t'(DRAIN_CYCLES);
          end
        end
        StFlush: begin
          if (cnt_q == phase_cnt_t'(1)) state_q <= StRun;
          cnt_q <= cnt_q - phase_cnt_t'(1);
        end
        StDrain: begin
          if (cnt_q == phase_cnt_t'(1)) state_q <= StHalted;
          cnt_q <= cnt_q - phase_cnt_t'(1);
        end
        StHalted: begin
`ifdef PIPELINE_CTRL_STEP_EN
          if (step) state_q <= StStep;
`else
          state_q <= StHalted;
`endif
        end
`ifdef PIPELINE_CTRL_STEP_EN
        StStep: state_q <= StHalted;
`endif
        default: state_q <= StRun;
      endcase

      // Saturate instead of wrapping.
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    pcEnable   = 1'b0;
    ifIdEnable = 1'b0;
    idExEnable = 1'b0;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    halted     = 1'b0;
    if (reset) begin
      unique case (state_q)
        StRun: begin
          if (exBranchTaken) begin
            pcEnable   = 1'b1;
            ifIdEnable = 1'b1;
            idExEnable = 1'b1;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
          end else if (hazard) begin
            // Hold PC and IF/ID, inject a bubble behind the load.
            idExEnable = 1'b1;
            idExFlush  = 1'b1;
          end else if (idHalt) begin
            // Freeze fetch; the halt itself advances into EX, IF/ID refills with a NOP.
            ifIdEnable = 1'b1;
            idExEnable = 1'b1;
            ifIdFlush  = 1'b1;
          end else begin
            pcEnable   = 1'b1;
            ifIdEnable = 1'b1;
            idExEnable = 1'b1;
          end
        end
        StFlush: begin
          pcEnable   = 1'b1;
          ifIdEnable = 1'b1;
          idExEnable = 1'b1;
          ifIdFlush  = 1'b1;
          idExFlush  = 1'b1;
        end
        StDrain: begin
          idExEnable = 1'b1;
          idExFlush  = 1'b1;
        end
        StHalted: halted = 1'b1;
`ifdef PIPELINE_CTRL_STEP_EN
        StStep: begin
          pcEnable   = 1'b1;
          ifIdEnable = 1'b1;
          idExEnable = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign stallCount = stall_cnt_q;
  assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl.
// Expected per-cycle outputs and counter values are queued when stimulus is applied and
// compared by a monitor on the falling edge. A second instance with CNT_W=2 receives the
// same stimulus to exercise counter saturation.
module tb_pipeline_ctrl;

  // Output vector order: {pcEnable, ifIdEnable, idExEnable, ifIdFlush, idExFlush, halted}
  localparam logic [5:0] ORst    = 6'b000000;
  localparam logic [5:0] ORun    = 6'b111000;
  localparam logic [5:0] OStall  = 6'b001010;
  localparam logic [5:0] OBr     = 6'b111110;
  localparam logic [5:0] OHalt   = 6'b011100;
  localparam logic [5:0] ODrain  = 6'b001010;
  localparam logic [5:0] OHalted = 6'b000001;
  localparam logic [5:0] OStep   = 6'b111000;

  typedef struct {
    string      tag;
    logic [5:0] outs;
    int         stall;
    int         flush;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, exMemRead, idUsesRt, exBranchTaken, idHalt, step;
  logic [4:0] exRegRt, idRegRs, idRegRt;

  logic        pcEnable, ifIdEnable, idExEnable, ifIdFlush, idExFlush, halted;
  logic [15:0] stallCount, flushCount;
  logic        s_pc, s_ifid, s_idex, s_iff, s_idf, s_halted;
  logic [1:0]  s_stall, s_flush;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .exMemRead     (exMemRead),
    .exRegRt       (exRegRt),
    .idRegRs       (idRegRs),
    .idRegRt       (idRegRt),
    .idUsesRt      (idUsesRt),
    .exBranchTaken (exBranchTaken),
    .idHalt        (idHalt),
    .step          (step),
    .pcEnable      (pcEnable),
    .ifIdEnable    (ifIdEnable),
    .idExEnable    (idExEnable),
    .ifIdFlush     (ifIdFlush),
    .idExFlush     (idExFlush),
    .halted        (halted),
    .stallCount    (stallCount),
    .flushCount    (flushCount)
  );

  pipeline_ctrl #(
    .CNT_W (2)
  ) dut_sat (
    .clk           (clk),
    .reset         (reset),
    .exMemRead     (exMemRead),
    .exRegRt       (exRegRt),
    .idRegRs       (idRegRs),
    .idRegRt       (idRegRt),
    .idUsesRt      (idUsesRt),
    .exBranchTaken (exBranchTaken),
    .idHalt        (idHalt),
    .step          (step),
    .pcEnable      (s_pc),
    .ifIdEnable    (s_ifid),
    .idExEnable    (s_idex),
    .ifIdFlush     (s_iff),
    .idExFlush     (s_idf),
    .halted        (s_halted),
    .stallCount    (s_stall),
    .flushCount    (s_flush)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of stimulus and queue what the outputs must look like during it.
  task automatic cyc(input string tag, input logic rst, input logic mr, input logic [4:0] ert,
                     input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                     input logic br, input logic hl, input logic st,
                     input logic [5:0] outs, input int es, input int ef);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    exMemRead     = mr;
    exRegRt       = ert;
    idRegRs       = rs;
    idRegRt       = rt;
    idUsesRt      = ut;
    exBranchTaken = br;
    idHalt        = hl;
    step          = st;
    e.tag   = tag;
    e.outs  = outs;
    e.stall = es;
    e.flush = ef;
    sb.push_back(e);
  endtask

  task automatic idle(input string tag, input logic [5:0] outs, input int es, input int ef);
    cyc(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, outs, es, ef);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check_eq({mon_e.tag, ".out"},
               32'({pcEnable, ifIdEnable, idExEnable, ifIdFlush, idExFlush, halted}),
               32'(mon_e.outs));
      check_eq({mon_e.tag, ".sat_out"},
               32'({s_pc, s_ifid, s_idex, s_iff, s_idf, s_halted}), 32'(mon_e.outs));
      check_eq({mon_e.tag, ".stall"}, 32'(stallCount), mon_e.stall);
      check_eq({mon_e.tag, ".flush"}, 32'(flushCount), mon_e.flush);
    end
  end

  initial begin
    reset = 1'b0; exMemRead = 1'b0; exRegRt = '0; idRegRs = '0; idRegRt = '0;
    idUsesRt = 1'b0; exBranchTaken = 1'b0; idHalt = 1'b0; step = 1'b0;

    cyc("rst0", 0, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 0, 0);
    cyc("rst1", 0, 1, 5, 5, 0, 0, 1, 1, 0, ORst, 0, 0);
    idle("run0", ORun, 0, 0);

    // Load-use detection
    cyc("stall_rs",  1, 1, 5, 5, 0, 0, 0, 0, 0, OStall, 0, 0);
    idle("after_stall", ORun, 1, 0);
    cyc("rt_zero",   1, 1, 0, 0, 0, 1, 0, 0, 0, ORun, 1, 0);
    cyc("rt_unused", 1, 1, 7, 3, 7, 0, 0, 0, 0, ORun, 1, 0);
    cyc("no_load",   1, 0, 5, 5, 5, 1, 0, 0, 0, ORun, 1, 0);
    cyc("stall_rt",  1, 1, 7, 3, 7, 1, 0, 0, 0, OStall, 1, 0);
    idle("after_rt", ORun, 2, 0);

    // Taken branch, penalty 2
    cyc("br", 1, 0, 0, 0, 0, 0, 1, 0, 0, OBr, 2, 0);
    idle("br_flush", OBr, 2, 1);
    idle("br_done", ORun, 2, 2);

    // Branch + hazard + halt together: flush only
    cyc("br_all",       1, 1, 5, 5, 0, 0, 1, 1, 0, OBr, 2, 2);
    cyc("br_all_flush", 1, 1, 5, 5, 0, 0, 0, 1, 0, OBr, 2, 3);
    idle("br_all_done", ORun, 2, 4);

    // Halt and drain
    cyc("halt",   1, 0, 0, 0, 0, 0, 0, 1, 0, OHalt, 2, 4);
    idle("drain1", ODrain, 2, 4);
    cyc("drain2", 1, 1, 5, 5, 0, 0, 1, 1, 0, ODrain, 2, 4);
    idle("drain3", ODrain, 2, 4);
    idle("drain4", ODrain, 2, 4);
    idle("halted1", OHalted, 2, 4);
    cyc("halted_step", 1, 0, 0, 0, 0, 0, 0, 0, 1, OHalted, 2, 4);
`ifdef PIPELINE_CTRL_STEP_EN
    cyc("step", 1, 0, 0, 0, 0, 0, 0, 0, 0, OStep, 2, 4);
`else
    cyc("step_ignored", 1, 0, 0, 0, 0, 0, 0, 0, 0, OHalted, 2, 4);
`endif
    idle("halted2", OHalted, 2, 4);
    cyc("halted3", 1, 1, 5, 5, 0, 0, 1, 1, 0, OHalted, 2, 4);
    check_eq("sat_flush_pre", 32'(s_flush), 32'd3);
    check_eq("sat_stall_pre", 32'(s_stall), 32'd2);

    // Reset out of HALTED clears counters
    cyc("rst_halted", 0, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 2, 4);
    idle("rst_rel", ORun, 0, 0);

    // Reset in the second DRAIN cycle
    cyc("halt2", 1, 0, 0, 0, 0, 0, 0, 1, 0, OHalt, 0, 0);
    idle("d1", ODrain, 0, 0);
    cyc("d2_rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, ORst, 0, 0);

    // Five stalls: 16-bit counter reaches 5, the 2-bit one saturates at 3
    cyc("after_rst", 1, 1, 5, 5, 0, 0, 0, 0, 0, OStall, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc($sformatf("sat%0d", i), 1, 1, 9, 9, 0, 0, 0, 0, 0, OStall, i + 1, 0);
    end
    idle("sat_done", ORun, 5, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    check_eq("sat_stall", 32'(s_stall), 32'd3);
    check_eq("sat_flush", 32'(s_flush), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameters: BRANCH_PENALTY, default 2 (1..3), flush cycles per taken branch; DRAIN_CYCLES, default 4 (1..15), cycles to empty the pipeline after a halt; CNT_W, default 16, performance-counter width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-low.
- exMemRead  in  1  MemRead of the instruction held in the ID/EX latch.
- exRegRt  in  5  Rt of the instruction held in the ID/EX latch.
- idRegRs  in  5  Rs of the instruction in ID.
- idRegRt  in  5  Rt of the instruction in ID.
- idUsesRt  in  1  the ID instruction reads Rt.
- exBranchTaken  in  1  taken branch resolved in EX this cycle.
- idHalt  in  1  halt opcode decoded in ID.
- step  in  1  single-step request (STEP_EN only).
- pcEnable  out  1  PC register load enable.
- ifIdEnable  out  1  IF/ID latch enable.
- idExEnable  out  1  ID/EX latch enable.
- ifIdFlush  out  1  IF/ID loads a NOP.
- idExFlush  out  1  ID/EX loads a bubble (all control bits 0).
- halted  out  1  core is halted.
- stallCount  out  CNT_W  load-use stall cycles.
- flushCount  out  CNT_W  branch-flush cycles.

Function
REQ-003 SHALL implement FSM states RUN, FLUSH, DRAIN, HALTED, plus STEP when STEP_EN is defined; outputs are combinational from state and inputs.
REQ-004 A load-use hazard SHALL be exMemRead && exRegRt!=0 && (exRegRt==idRegRs || (idUsesRt && exRegRt==idRegRt)).
REQ-005 RUN, no event: pcEnable=ifIdEnable=idExEnable=1, both flushes=0.
REQ-006 RUN with hazard only: pcEnable=0, ifIdEnable=0, idExFlush=1 for that cycle; stallCount+1; state stays RUN.
REQ-007 RUN with exBranchTaken: ifIdFlush=1, idExFlush=1, pcEnable=1; flushCount+1; if BRANCH_PENALTY>1, go to FLUSH with cnt=BRANCH_PENALTY-1.
REQ-008 FLUSH: same outputs as REQ-007 and flushCount+1 each cycle; cnt decrements; go to RUN on the edge where cnt==1.
REQ-009 RUN with idHalt and no branch: pcEnable=0, ifIdFlush=1, idExEnable=1; go to DRAIN with cnt=DRAIN_CYCLES.
REQ-010 DRAIN: pcEnable=0, ifIdEnable=0, idExFlush=1; exBranchTaken, idHalt and the hazard are ignored; go to HALTED on the edge where cnt==1.
REQ-011 HALTED: pcEnable=ifIdEnable=idExEnable=0, flushes=0, halted=1; the state persists until reset.
REQ-012 Priority within RUN SHALL be exBranchTaken > hazard > idHalt; a branch squashes a simultaneous halt and stall, and no stall is counted.
REQ-013 Counters SHALL saturate at 2^CNT_W-1 with no wrap.

Reset
REQ-014 While reset=0 at a clock edge: state becomes RUN, cnt=0, and both counters become 0.
REQ-015 While reset=0, all enables, flushes and halted SHALL be 0.
REQ-016 Reset in any state, including mid-FLUSH or mid-DRAIN, SHALL abort that state; the first cycle after release behaves as RUN.

Configuration
REQ-017 With macro PIPELINE_CTRL_STEP_EN defined:
- In HALTED, step=1 moves to STEP.
- STEP drives pcEnable=ifIdEnable=idExEnable=1 and halted=0 for exactly one cycle, then returns to HALTED.
- step is ignored in every other state.
REQ-018 Without PIPELINE_CTRL_STEP_EN: the step port exists but is ignored, and the STEP state is absent.

Structure
REQ-019 Package pipeline_ctrl_pkg SHALL hold the state enumeration and the default values of BRANCH_PENALTY, DRAIN_CYCLES and CNT_W.
REQ-020 REQ-004 SHALL be a combinational sub-module load_use_detect; the FSM, counters and output decode stay in pipeline_ctrl.

Verification
REQ-021 Bench SHALL cover:
- exMemRead=1, exRegRt=5, idRegRs=5 for 1 cycle -> pcEnable=0, ifIdEnable=0, idExFlush=1; stallCount=1.
- exRegRt=0 with matching idRegRs, or idUsesRt=0 with Rt-only match -> no stall.
- BRANCH_PENALTY=2, exBranchTaken pulse -> flushes high 2 cycles, then RUN; flushCount=2.
- exBranchTaken, hazard and idHalt in the same cycle -> flush only; stallCount unchanged; no DRAIN.
- idHalt, DRAIN_CYCLES=4 -> 4 DRAIN cycles, then halted=1 with all enables 0; reset asserted in cycle 2 of DRAIN -> RUN, counters 0.
- STEP_EN, HALTED with step pulse -> exactly 1 cycle of all enables=1, then halted=1 again; CNT_W=2 with 5 stalls -> stallCount=3.
